// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module   : reg_scoreboard
// Brief    : Producer-side register hazard tracker; stalls ID until a source
//            value can be supplied by a forwarding path.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_scoreboard #(
    parameter int CNT_W    = 2,
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 3,
    parameter int LAT_W    = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ID_Valid_i,
    input  logic [4:0] ID_RS1_i,
    input  logic [4:0] ID_RS2_i,
    input  logic       ID_Use_RS1_i,
    input  logic       ID_Use_RS2_i,
    input  logic [4:0] ID_Rd_i,
    input  logic       ID_RegWrite_i,
    input  logic [1:0] ID_Class_i,
    input  logic [4:0] WB_Rd_i,
    input  logic       WB_RegWrite_i,
    output logic       Stall_o,
    output logic       Busy_o,
    output logic       Err_o
);

    localparam logic [LAT_W-1:0] c_LOAD_CD = LAT_W'(LOAD_LAT);
    localparam logic [LAT_W-1:0] c_MUL_CD  = LAT_W'(MUL_LAT);

    // Index 0 models x0: permanently idle, never written.
    logic [CNT_W-1:0] w_pend [0:31];
    logic [LAT_W-1:0] w_cd   [0:31];
    logic [31:0]      w_nz;

    logic             w_issue;
    logic             w_retire;
    logic             w_err_set;
    logic             w_haz_rs1;
    logic             w_haz_rs2;
    logic             w_sat;
    logic [LAT_W-1:0] w_issue_cd;
    logic             r_err;

    assign w_pend[0] = '0;
    assign w_cd[0]   = '0;
    assign w_nz[0]   = 1'b0;

    always_comb begin
        w_haz_rs1 = ID_Use_RS1_i && (ID_RS1_i != 5'd0) && (w_cd[ID_RS1_i] != '0);
        w_haz_rs2 = ID_Use_RS2_i && (ID_RS2_i != 5'd0) && (w_cd[ID_RS2_i] != '0);
        w_sat     = ID_RegWrite_i && (ID_Rd_i != 5'd0) && (w_pend[ID_Rd_i] == '1);
        Stall_o   = ID_Valid_i && (w_haz_rs1 || w_haz_rs2 || w_sat);
        w_issue   = ID_Valid_i && ID_RegWrite_i && (ID_Rd_i != 5'd0) && !Stall_o;
        w_retire  = WB_RegWrite_i && (WB_Rd_i != 5'd0);
        w_err_set = w_retire && (w_pend[WB_Rd_i] == '0);
    end

    always_comb begin
        w_issue_cd = c_MUL_CD;
        case (ID_Class_i)
            2'b00:   w_issue_cd = '0;
            2'b01:   w_issue_cd = c_LOAD_CD;
            default: w_issue_cd = c_MUL_CD;
        endcase
    end

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            logic [CNT_W-1:0] r_pend;
            logic [LAT_W-1:0] r_cd;
            logic [CNT_W-1:0] w_pend_nx;
            logic [LAT_W-1:0] w_cd_nx;
            logic             w_iss_hit;
            logic             w_ret_hit;

            always_comb begin
                w_iss_hit = w_issue  && (ID_Rd_i == 5'(gi));
                w_ret_hit = w_retire && (WB_Rd_i == 5'(gi));

                w_pend_nx = r_pend;
                if (w_iss_hit && !w_ret_hit)
                    w_pend_nx = r_pend + CNT_W'(1);
                else if (w_ret_hit && !w_iss_hit && (r_pend != '0))
                    w_pend_nx = r_pend - CNT_W'(1);

                // Newest producer defines readiness; idle registers never stall.
                w_cd_nx = (r_cd != '0) ? r_cd - LAT_W'(1) : '0;
                if (w_iss_hit)
                    w_cd_nx = w_issue_cd;
                if (w_pend_nx == '0)
                    w_cd_nx = '0;
            end

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_pend <= '0;
                    r_cd   <= '0;
                end else begin
                    r_pend <= w_pend_nx;
                    r_cd   <= w_cd_nx;
                end
            end

            assign w_pend[gi] = r_pend;
            assign w_cd[gi]   = r_cd;
            assign w_nz[gi]   = (r_pend != '0);
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            r_err <= 1'b0;
        else if (w_err_set)
            r_err <= 1'b1;
    end

    assign Busy_o = |w_nz;
    assign Err_o  = r_err;

endmodule

`default_nettype wire

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Producer-side hazard tracker for the 5-stage pipeline. It records every register write issued from ID and retires it at WB.
- It tells ID when a source register's value cannot yet be supplied by the EX/MEM or MEM/WB forwarding paths, which covers load-use and multi-cycle MUL results, and asserts Stall_o.
- It complements the EX-stage forwarding unit: forwarding selects where a ready value comes from, and this block holds issue until the value exists on one of those paths.

Parameters:
- CNT_W, 2: width of the per-register in-flight write counter; the maximum number of in-flight writes per register is 2^CNT_W-1.
- LOAD_LAT, 1: stall cycles required after a load issues before a dependent instruction may issue.
- MUL_LAT, 3: stall cycles required after a MUL issues before a dependent instruction may issue.
- LAT_W, 2: countdown width; it must satisfy 2^LAT_W-1 >= max(LOAD_LAT, MUL_LAT).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- ID_Valid_i  in  1  a valid instruction is in ID.
- ID_RS1_i  in  5  source register 1 of the ID instruction.
- ID_RS2_i  in  5  source register 2 of the ID instruction.
- ID_Use_RS1_i  in  1  the instruction reads RS1.
- ID_Use_RS2_i  in  1  the instruction reads RS2.
- ID_Rd_i  in  5  destination register of the ID instruction.
- ID_RegWrite_i  in  1  the ID instruction writes Rd.
- ID_Class_i  in  2  result class: 00 ALU, 01 LOAD, 10 MUL, 11 reserved (treated as MUL).
- WB_Rd_i  in  5  destination register of the instruction retiring in WB.
- WB_RegWrite_i  in  1  the WB instruction writes Rd.
- Stall_o  out  1  hold the PC and IF/ID registers and insert a bubble into ID/EX.
- Busy_o  out  1  at least one register has a write in flight.
- Err_o  out  1  sticky: a retire arrived for a register with no pending write.

Behaviour:
- Per-register state for x1..x31: pend[r] (CNT_W-bit counter) and cd[r] (LAT_W-bit countdown). x0 is never tracked: its pend and cd are constant 0 and any access to it is ignored.
- Reset (rst_i=0, asynchronous): all pend=0, all cd=0, Err_o=0. While reset is asserted, Stall_o=0 and Busy_o=0. Reset may hit mid-operation; all in-flight tracking is discarded.
- Stall_o is combinational from the current state and the ID inputs. It is 1 when ID_Valid_i=1 and any of the following holds:
  - ID_Use_RS1_i=1, RS1!=0, cd[RS1]!=0.
  - ID_Use_RS2_i=1, RS2!=0, cd[RS2]!=0.
  - ID_RegWrite_i=1, Rd!=0, and pend[Rd] is all-ones (counter saturation; structural stall).
- issue = ID_Valid_i & ID_RegWrite_i & (ID_Rd_i!=0) & !Stall_o.
- retire = WB_RegWrite_i & (WB_Rd_i!=0).
- Every clock edge, in this order of precedence:
  - All nonzero cd entries decrement by 1.
  - On issue: pend[Rd]+=1, and cd[Rd] loads 0 for ALU, LOAD_LAT for LOAD, MUL_LAT for MUL/reserved. The load overrides the decrement for that register (WAW: the newest producer defines readiness).
  - On retire: if pend[WB_Rd]!=0 then pend[WB_Rd]-=1; otherwise pend is unchanged and Err_o<=1.
  - Issue and retire to the same register in the same cycle: pend is unchanged (net 0) and cd loads per the issue rule.
  - If pend[r] reaches 0 by this edge, cd[r] is forced to 0.
- Issue-to-stall timing, with issue in cycle t:
  - LOAD: a dependent in ID stalls for cycle t+1 only and issues in t+2, forwarded from MEM/WB.
  - MUL: a dependent stalls for t+1..t+MUL_LAT.
  - ALU: no stall; the EX/MEM path covers the dependency.
- Busy_o is the OR of all pend[r]!=0, registered view (reflects state after the last edge).
- Branches resolve in ID, so issued instructions are never squashed. Every issue has exactly one matching WB retire.
- A reserved class (11) behaves exactly like MUL.

Test Plan:
- Reset: pulse rst_i low asynchronously mid-cycle while pend[5]=1 and cd[5]=2 -> immediately Stall_o=0, Busy_o=0, Err_o=0; after release, RS1=5 in ID does not stall.
- Load-use: issue LOAD Rd=3 at t; at t+1 ID reads RS2=3 -> Stall_o=1 at t+1 only, 0 at t+2. Retire Rd=3 later -> Busy_o=0 the next cycle.
- MUL latency: issue MUL Rd=7 at t; dependent on RS1=7 -> Stall_o=1 for t+1..t+3 and 0 at t+4. ALU Rd=8 then dependent on 8 -> never stalls.
- x0 and unused sources: LOAD Rd=0 -> pend unchanged, Busy_o stays 0. Dependent with ID_Use_RS1_i=0 but RS1 matching a pending load -> Stall_o=0.
- WAW and simultaneous events: LOAD Rd=4 then ALU Rd=4 -> cd[4]=0 and pend[4]=2. Issue Rd=4 while WB retires Rd=4 -> pend stays 2. With CNT_W=2, a 4th write to x4 with pend=3 -> Stall_o=1 until one retires.
- Error: WB_RegWrite_i=1, WB_Rd_i=9 with pend[9]=0 -> Err_o=1 and held until reset; pend[9] stays 0.
